// File: rtl/pu_max_score_tracker_pkg.sv
// Shared design variables for the max-score tracker: tile geometry, score and
// coordinate widths, the tracker state type and the pipeline candidate record.
package pu_max_score_tracker_pkg;

   localparam int NUM_ROWS_PE = 4;
   localparam int NUM_COLS_PE = 4;
   localparam int SCORE_WIDTH = 8;
   localparam int POS_WIDTH   = 10;
   localparam int CNT_WIDTH   = 16;

   localparam int TILE_WIDTH  = NUM_ROWS_PE * NUM_COLS_PE * SCORE_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } trackerState_t;

   // One scored position travelling down the reduction pipeline
   typedef struct packed {
      logic [SCORE_WIDTH-1:0] score;
      logic [POS_WIDTH-1:0]   row;
      logic [POS_WIDTH-1:0]   col;
   } candidate_t;

   // Pulls element [row][col] out of a packed processing-unit score tile,
   // where element 0 sits in the least significant bits and columns run fastest
   function automatic logic [SCORE_WIDTH-1:0] tileScore(
      input logic [TILE_WIDTH-1:0] tile,
      input int                    row,
      input int                    col
   );
      return tile[(row * NUM_COLS_PE + col) * SCORE_WIDTH +: SCORE_WIDTH];
   endfunction

endpackage

// File: rtl/pu_max_score_tracker_if.sv
// Tile bus from the processing unit into the max-score tracker: one score tile
// per valid cycle, tagged with its tile coordinates and an end-of-alignment flag.
interface pu_max_score_tracker_if;
   import pu_max_score_tracker_pkg::*;

   logic                  tile_valid;
   logic                  tile_last;
   logic [POS_WIDTH-1:0]  tile_row_idx;
   logic [POS_WIDTH-1:0]  tile_col_idx;
   logic [TILE_WIDTH-1:0] scores_in;

   modport master (
      output tile_valid,
      output tile_last,
      output tile_row_idx,
      output tile_col_idx,
      output scores_in
   );

   modport slave (
      input tile_valid,
      input tile_last,
      input tile_row_idx,
      input tile_col_idx,
      input scores_in
   );

endinterface

// File: rtl/pu_max_score_tracker_score_max_reduce.sv
// Combinational max-with-position over N candidates. Ties resolve to the
// lowest-index candidate, which gives raster-order priority when the caller
// orders candidates by row then column.
module score_max_reduce
   import pu_max_score_tracker_pkg::*;
#(
   parameter int N = 4
)
(
   input  candidate_t candidates [N],
   output candidate_t winner
);

   // Linear scan with a strict compare so an equal later score never displaces an earlier one
   always_comb begin
      winner = candidates[0];
      for (int i = 1; i < N; i++) begin
         if (candidates[i].score > winner.score) begin
            winner = candidates[i];
         end
      end
   end

endmodule

// File: rtl/pu_max_score_tracker.sv
// Tracks the maximum local-alignment score and its absolute matrix position
// over a whole alignment. Each accepted tile is reduced per row (S1), then
// across rows into absolute coordinates (S2), then folded into a running max.
// The result is the traceback start point for the traceback controller.
module pu_max_score_tracker
   import pu_max_score_tracker_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   pu_max_score_tracker_if.slave        tileBus,
   output logic                         busy,
   output logic                         result_valid,
   output logic [SCORE_WIDTH-1:0]       max_score,
   output logic [POS_WIDTH-1:0]         max_row,
   output logic [POS_WIDTH-1:0]         max_col,
   output logic [CNT_WIDTH-1:0]         tile_count,
   output logic                         tile_err
);

   localparam logic [POS_WIDTH-1:0] ROW_STRIDE = POS_WIDTH'(NUM_ROWS_PE);
   localparam logic [POS_WIDTH-1:0] COL_STRIDE = POS_WIDTH'(NUM_COLS_PE);

   trackerState_t state;
   trackerState_t nextState;
   logic          drainCnt;

   logic          acceptTile;
   logic          strayTile;

   candidate_t           rowBest [NUM_ROWS_PE];
   candidate_t           s1Best  [NUM_ROWS_PE];
   logic [POS_WIDTH-1:0] s1TileRow;
   logic [POS_WIDTH-1:0] s1TileCol;
   logic                 s1Valid;

   candidate_t           tileBest;
   logic [POS_WIDTH-1:0] absRow;
   logic [POS_WIDTH-1:0] absCol;
   candidate_t           s2Best;
   logic                 s2Valid;

   // A start pulse wins over any tile presented in the same cycle
   assign acceptTile = (state == ACCUM) && tileBus.tile_valid && !start;
   assign strayTile  = (state != ACCUM) && tileBus.tile_valid && !start;

   // S1 candidates carry tile-local row/col; per-row reducers pick each row's best column
   for (genvar r = 0; r < NUM_ROWS_PE; r++) begin : gRow
      candidate_t colCands [NUM_COLS_PE];

      for (genvar c = 0; c < NUM_COLS_PE; c++) begin : gCol
         assign colCands[c] = '{score: tileScore(tileBus.scores_in, r, c),
                                row:   POS_WIDTH'(r),
                                col:   POS_WIDTH'(c)};
      end

      score_max_reduce #(.N(NUM_COLS_PE)) rowReduce (
         .candidates (colCands),
         .winner     (rowBest[r])
      );
   end

   // S2 reducer picks the best row; row order gives the lower row priority on ties
   score_max_reduce #(.N(NUM_ROWS_PE)) tileReduce (
      .candidates (s1Best),
      .winner     (tileBest)
   );

   // Absolute coordinates wrap modulo 2^POS_WIDTH by construction of the widths
   assign absRow = s1TileRow * ROW_STRIDE + tileBest.row;
   assign absCol = s1TileCol * COL_STRIDE + tileBest.col;

   // Pipeline valid bits: cleared by reset, flushed by start so in-flight tiles are discarded
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
      end else if (start) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
      end else begin
         s1Valid <= acceptTile;
         s2Valid <= s1Valid;
      end
   end

   // Pipeline data registers only load when their stage input is valid; valid bits guard their use
   always_ff @(posedge clk) begin
      if (acceptTile) begin
         s1Best    <= rowBest;
         s1TileRow <= tileBus.tile_row_idx;
         s1TileCol <= tileBus.tile_col_idx;
      end
      if (s1Valid) begin
         s2Best <= '{score: tileBest.score, row: absRow, col: absCol};
      end
   end

   // Running max replaces only on a strictly greater tile max, so earlier tiles keep ties
   always_ff @(posedge clk) begin
      if (rst || start) begin
         max_score <= '0;
         max_row   <= '0;
         max_col   <= '0;
      end else if (s2Valid && (s2Best.score > max_score)) begin
         max_score <= s2Best.score;
         max_row   <= s2Best.row;
         max_col   <= s2Best.col;
      end
   end

   // Accepted-tile counter wraps naturally at its width
   always_ff @(posedge clk) begin
      if (rst || start) begin
         tile_count <= '0;
      end else if (acceptTile) begin
         tile_count <= tile_count + 1'b1;
      end
   end

   // Sticky flag for tiles that arrive while the tracker is not accumulating
   always_ff @(posedge clk) begin
      if (rst || start) begin
         tile_err <= 1'b0;
      end else if (strayTile) begin
         tile_err <= 1'b1;
      end
   end

   // State register plus the drain cycle counter that times out the pipeline tail
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         drainCnt <= 1'b0;
      end else begin
         state    <= nextState;
         drainCnt <= (state == DRAIN) ? drainCnt + 1'b1 : 1'b0;
      end
   end

   // Next-state and status outputs; DRAIN lasts two cycles so the last tile reaches the running max
   always_comb begin
      nextState    = state;
      busy         = 1'b0;
      result_valid = 1'b0;

      case (state)
         IDLE: begin
            nextState = IDLE;
         end
         ACCUM: begin
            busy = 1'b1;
            if (acceptTile && tileBus.tile_last) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drainCnt) begin
               nextState = DONE;
            end
         end
         DONE: begin
            result_valid = 1'b1;
         end
         default: begin
            nextState = IDLE;
         end
      endcase

      if (start) begin
         nextState = ACCUM;
      end
   end

endmodule

// File: tb/tb_pu_max_score_tracker.sv
// Self-checking bench for pu_max_score_tracker. A cycle-level behavioural
// model (raster scan per tile, a delay queue for pipeline latency, and a
// simple mode variable) is compared against the DUT after every clock edge;
// directed scenarios add literal expectations that pin the model.
module tb_pu_max_score_tracker;
   import pu_max_score_tracker_pkg::*;

   localparam int M_IDLE  = 0;
   localparam int M_ACCUM = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;
   localparam int POS_MOD = 1 << POS_WIDTH;
   localparam int CNT_MOD = 1 << CNT_WIDTH;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic                   busy;
   logic                   result_valid;
   logic [SCORE_WIDTH-1:0] max_score;
   logic [POS_WIDTH-1:0]   max_row;
   logic [POS_WIDTH-1:0]   max_col;
   logic [CNT_WIDTH-1:0]   tile_count;
   logic                   tile_err;

   pu_max_score_tracker_if tileIf();

   pu_max_score_tracker dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .tileBus      (tileIf),
      .busy         (busy),
      .result_valid (result_valid),
      .max_score    (max_score),
      .max_row      (max_row),
      .max_col      (max_col),
      .tile_count   (tile_count),
      .tile_err     (tile_err)
   );

   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;

   int tileArr [NUM_ROWS_PE][NUM_COLS_PE];

   typedef struct {
      int score;
      int row;
      int col;
      int due;
   } pend_t;

   pend_t pending[$];
   pend_t pItem;
   int    mState = M_IDLE;
   int    mDrain = 0;
   int    mMax   = 0;
   int    mRow   = 0;
   int    mCol   = 0;
   int    mCount = 0;
   int    mErr   = 0;
   int    mEdge  = 0;
   bit    modelReady = 1'b0;

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs on the falling edge from the tileArr scratch tile
   task automatic applyStimulus(input bit doReset, input bit s, input bit v, input bit l,
                                input int rIdx, input int cIdx);
      @(negedge clk);
      rst                 = doReset;
      start               = s;
      tileIf.tile_valid   = v;
      tileIf.tile_last    = l;
      tileIf.tile_row_idx = POS_WIDTH'(rIdx);
      tileIf.tile_col_idx = POS_WIDTH'(cIdx);
      for (int i = 0; i < NUM_ROWS_PE; i++) begin
         for (int j = 0; j < NUM_COLS_PE; j++) begin
            tileIf.scores_in[(i * NUM_COLS_PE + j) * SCORE_WIDTH +: SCORE_WIDTH] = SCORE_WIDTH'(tileArr[i][j]);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic clearTile(input int fill);
      for (int i = 0; i < NUM_ROWS_PE; i++) begin
         for (int j = 0; j < NUM_COLS_PE; j++) tileArr[i][j] = fill;
      end
   endtask

   // Idles until result_valid shows up, bounded by a cycle budget
   task automatic waitResult(input int budget);
      int n;
      n = 0;
      while (result_valid !== 1'b1 && n < budget) begin
         idle(1);
         n++;
      end
      checkOutput("result_valid_wait", 32'(result_valid), 32'd1);
   endtask

   // Behavioural model: tiles become visible in the running max two edges after acceptance
   always @(posedge clk) begin
      int preState;
      int best, bi, bj, s;
      mEdge++;
      if (rst === 1'b1) begin
         mState = M_IDLE; mDrain = 0; mMax = 0; mRow = 0; mCol = 0;
         mCount = 0; mErr = 0; pending.delete(); modelReady = 1'b1;
      end else if (start === 1'b1) begin
         mState = M_ACCUM; mDrain = 0; mMax = 0; mRow = 0; mCol = 0;
         mCount = 0; mErr = 0; pending.delete();
      end else begin
         while (pending.size() > 0 && pending[0].due == mEdge) begin
            pItem = pending.pop_front();
            if (pItem.score > mMax) begin
               mMax = pItem.score; mRow = pItem.row; mCol = pItem.col;
            end
         end
         preState = mState;
         if (preState == M_DRAIN) begin
            mDrain--;
            if (mDrain == 0) mState = M_DONE;
         end
         if (tileIf.tile_valid === 1'b1) begin
            if (preState == M_ACCUM) begin
               best = -1; bi = 0; bj = 0;
               for (int i = 0; i < NUM_ROWS_PE; i++) begin
                  for (int j = 0; j < NUM_COLS_PE; j++) begin
                     s = int'(tileIf.scores_in[(i * NUM_COLS_PE + j) * SCORE_WIDTH +: SCORE_WIDTH]);
                     if (s > best) begin best = s; bi = i; bj = j; end
                  end
               end
               pItem.score = best;
               pItem.row   = (int'(tileIf.tile_row_idx) * NUM_ROWS_PE + bi) % POS_MOD;
               pItem.col   = (int'(tileIf.tile_col_idx) * NUM_COLS_PE + bj) % POS_MOD;
               pItem.due   = mEdge + 2;
               pending.push_back(pItem);
               mCount = (mCount + 1) % CNT_MOD;
               if (tileIf.tile_last === 1'b1) begin
                  mState = M_DRAIN;
                  mDrain = 2;
               end
            end else begin
               mErr = 1;
            end
         end
      end
   end

   // Compare every output against the model shortly after each active edge
   always @(posedge clk) begin
      #1;
      if (modelReady) begin
         checkOutput("cyc_busy", 32'(busy), 32'((mState == M_ACCUM) || (mState == M_DRAIN)));
         checkOutput("cyc_result_valid", 32'(result_valid), 32'(mState == M_DONE));
         checkOutput("cyc_max_score", 32'(max_score), 32'(mMax));
         checkOutput("cyc_max_row", 32'(max_row), 32'(mRow));
         checkOutput("cyc_max_col", 32'(max_col), 32'(mCol));
         checkOutput("cyc_tile_count", 32'(tile_count), 32'(mCount));
         checkOutput("cyc_tile_err", 32'(tile_err), 32'(mErr));
      end
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios with hand-computed literal expectations
   initial begin
      rst = 1'b1; start = 1'b0;
      tileIf.tile_valid = 1'b0; tileIf.tile_last = 1'b0;
      tileIf.tile_row_idx = '0; tileIf.tile_col_idx = '0; tileIf.scores_in = '0;
      clearTile(0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
      checkOutput("reset_max_score", 32'(max_score), 32'd0);
      checkOutput("reset_tile_count", 32'(tile_count), 32'd0);
      checkOutput("reset_tile_err", 32'(tile_err), 32'd0);
      idle(1);

      // Single tile: 37 at [2][1], result three cycles after acceptance
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      clearTile(0); tileArr[2][1] = 37;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      idle(1);
      checkOutput("t1_rv_t+1", 32'(result_valid), 32'd0);
      idle(1);
      checkOutput("t1_rv_t+2", 32'(result_valid), 32'd0);
      idle(1);
      checkOutput("t1_rv_t+3", 32'(result_valid), 32'd1);
      checkOutput("t1_max_score", 32'(max_score), 32'd37);
      checkOutput("t1_max_row", 32'(max_row), 32'd2);
      checkOutput("t1_max_col", 32'(max_col), 32'd1);
      checkOutput("t1_tile_count", 32'(tile_count), 32'd1);

      // Three back-to-back tiles; equal 50 in a later tile must not move the position
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      clearTile(3); tileArr[1][1] = 20;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      clearTile(7); tileArr[3][0] = 50;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
      clearTile(2); tileArr[0][0] = 50;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1, 1);
      waitResult(10);
      checkOutput("t2_max_score", 32'(max_score), 32'd50);
      checkOutput("t2_max_row", 32'(max_row), 32'd3);
      checkOutput("t2_max_col", 32'(max_col), 32'd4);
      checkOutput("t2_tile_count", 32'(tile_count), 32'd3);

      // Raster-order tie inside one tile
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      clearTile(0); tileArr[1][3] = 9; tileArr[1][2] = 9; tileArr[2][0] = 9;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      waitResult(10);
      checkOutput("t3_max_row", 32'(max_row), 32'd1);
      checkOutput("t3_max_col", 32'(max_col), 32'd2);

      // Coordinate wrap: (300*4+3) mod 1024 = 179, (255*4+3) = 1023
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      clearTile(1); tileArr[3][3] = 200;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 300, 255);
      waitResult(10);
      checkOutput("wrap_max_score", 32'(max_score), 32'd200);
      checkOutput("wrap_max_row", 32'(max_row), 32'd179);
      checkOutput("wrap_max_col", 32'(max_col), 32'd1023);

      // All-zero alignment reports zero at the origin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      clearTile(0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5, 5);
      waitResult(10);
      checkOutput("zero_max_score", 32'(max_score), 32'd0);
      checkOutput("zero_max_row", 32'(max_row), 32'd0);
      checkOutput("zero_max_col", 32'(max_col), 32'd0);

      // Restart mid-ACCUM, first after 99 is visible, then with 99 still in flight
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      clearTile(0); tileArr[0][0] = 99;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      idle(3);
      checkOutput("t4_max_99", 32'(max_score), 32'd99);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      idle(1);
      checkOutput("t4_cleared", 32'(max_score), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      idle(3);
      checkOutput("t4_flushed", 32'(max_score), 32'd0);
      clearTile(0); tileArr[2][2] = 5;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      waitResult(10);
      checkOutput("t4_max_score", 32'(max_score), 32'd5);
      checkOutput("t4_max_row", 32'(max_row), 32'd2);
      checkOutput("t4_tile_count", 32'(tile_count), 32'd1);

      // Tile in DONE is dropped and flags tile_err; start clears it
      clearTile(0); tileArr[0][0] = 200;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      idle(3);
      checkOutput("t5_done_err", 32'(tile_err), 32'd1);
      checkOutput("t5_done_max", 32'(max_score), 32'd5);
      checkOutput("t5_done_count", 32'(tile_count), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      idle(1);
      checkOutput("t5_err_cleared", 32'(tile_err), 32'd0);

      // tile_last without tile_valid does nothing
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      idle(3);
      checkOutput("lastonly_busy", 32'(busy), 32'd1);
      checkOutput("lastonly_count", 32'(tile_count), 32'd0);

      // Reset during DRAIN returns everything to zero and suppresses result_valid
      clearTile(0); tileArr[1][1] = 77;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(1);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_result_valid", 32'(result_valid), 32'd0);
      checkOutput("t6_max_score", 32'(max_score), 32'd0);
      checkOutput("t6_tile_count", 32'(tile_count), 32'd0);
      idle(4);
      checkOutput("t6_no_result", 32'(result_valid), 32'd0);

      // Tile in IDLE sets tile_err without touching the max or the count
      clearTile(0); tileArr[0][1] = 66;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      idle(3);
      checkOutput("t5_idle_err", 32'(tile_err), 32'd1);
      checkOutput("t5_idle_max", 32'(max_score), 32'd0);
      checkOutput("t5_idle_count", 32'(tile_count), 32'd0);

      // A tile coincident with start is ignored entirely
      clearTile(0); tileArr[3][1] = 88;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      idle(4);
      checkOutput("startcoin_err", 32'(tile_err), 32'd0);
      checkOutput("startcoin_count", 32'(tile_count), 32'd0);
      checkOutput("startcoin_max", 32'(max_score), 32'd0);
      checkOutput("startcoin_busy", 32'(busy), 32'd1);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pu_max_score_tracker.md
Name: pu_max_score_tracker

Overview:
Consumes the per-cycle score tile produced by the processing unit, an NUM_ROWS_PE x NUM_COLS_PE score array. Over a whole alignment it finds the maximum local-alignment score and that score's absolute matrix coordinates. This is the traceback start point used by the traceback controller. The block uses a two-stage pipelined reduction tree plus a running-max register, all under a small control FSM.

Parameters:
NUM_ROWS_PE, package value, PE rows per tile (from design_variables).
NUM_COLS_PE, package value, PE columns per tile (from design_variables).
SCORE_WIDTH, package value, unsigned score width (from design_variables).
POS_WIDTH, 10, width of absolute row/column coordinates and of tile indices.
CNT_WIDTH, 16, width of the accepted-tile counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; clears the tracker and begins a new alignment
tile_valid  in  1  scores_in and indices valid this cycle
tile_last  in  1  qualifies tile_valid; marks the final tile of the alignment
tile_row_idx  in  POS_WIDTH  tile row index (database direction)
tile_col_idx  in  POS_WIDTH  tile column index (query direction)
scores_in  in  NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH  packed [row][col] tile scores (processing unit scores_out)
busy  out  1  high in ACCUM and DRAIN
result_valid  out  1  high in DONE
max_score  out  SCORE_WIDTH  running/final maximum
max_row  out  POS_WIDTH  absolute row of maximum
max_col  out  POS_WIDTH  absolute column of maximum
tile_count  out  CNT_WIDTH  tiles accepted since start
tile_err  out  1  sticky; a tile arrived while not in ACCUM

Behaviour:
- Reset (synchronous, rst=1 at clk edge): FSM=IDLE; busy=0, result_valid=0, max_score=0, max_row=0, max_col=0, tile_count=0, tile_err=0; pipeline valid bits cleared.
- States:
  - IDLE: wait for start, then go to ACCUM.
  - ACCUM: every cycle with tile_valid=1 is accepted (throughput 1 tile/cycle, no backpressure). Accepted tile_valid & tile_last moves to DRAIN.
  - DRAIN: 2-cycle counter, then go to DONE.
  - DONE: holds results until start.
- start in any state, including mid-ACCUM/DRAIN: running max, position, tile_count and tile_err cleared; pipeline valid bits flushed; next state ACCUM. A tile_valid in the same cycle as start is ignored.
- Pipeline, with the tile accepted in cycle t:
  - S1 registers per-row max and column index at end of t.
  - S2 registers tile max, row and column at end of t+1.
  - Running max updates at end of t+2.
  - For the last tile, result_valid rises in cycle t+3.
- Tie-break within a tile: the lowest row wins, then the lowest column (first in raster order). Across tiles, the replacement condition is strictly greater, so the earlier tile keeps the position on equal scores.
- Coordinates: max_row = tile_row_idx*NUM_ROWS_PE + i and max_col = tile_col_idx*NUM_COLS_PE + j, truncated to POS_WIDTH (modulo wrap; no saturation). Tile indices travel down the pipeline with the data.
- Scores are unsigned. An all-zero alignment yields max_score=0 at position (0,0).
- tile_count increments per accepted tile and wraps at 2^CNT_WIDTH.
- tile_valid outside ACCUM: the tile is dropped and tile_err is set. tile_err clears only on start or rst.
- tile_last without tile_valid has no effect.
- max_* outputs track the running value during ACCUM/DRAIN and are stable in DONE.

Decomposition:
- design_variables package:
  - tracker state enum (IDLE, ACCUM, DRAIN, DONE)
  - POS_WIDTH and CNT_WIDTH constants
  - a struct {score, row, col} used for pipeline candidates
- Sub-module score_max_reduce: a combinational max-with-index over N candidates using the lowest-index tie-break. It is instantiated per row in S1 and once across rows in S2.

Test Plan:
(All scenarios use 4x4 tiles and SCORE_WIDTH=8.)
1. Single tile (0,0) with score 37 at [2][1] and zeros elsewhere, tile_last=1 -> result_valid 3 cycles later, max_score=37, max_row=2, max_col=1, tile_count=1.
2. Three tiles back-to-back: (0,0) max 20, (0,1) max 50 at [3][0], (1,1) max 50 at [0][0] -> max_score=50, row=3, col=4 (earlier tile wins the tie), tile_count=3.
3. Tie inside one tile: 9 at [1][3] and at [1][2] and at [2][0] -> max_row=1, max_col=2.
4. start pulsed mid-ACCUM after a tile with max 99 -> max_score=0 next cycle; a following tile with max 5 and tile_last yields max_score=5; the earlier 99 never reappears.
5. tile_valid in IDLE and in DONE -> tile_err=1; max_score and tile_count unchanged; start clears tile_err.
6. rst asserted in DRAIN -> next cycle all outputs are zero and FSM is IDLE; result_valid never pulses.
